// File: rtl/row_dma_writer_if.sv
// Row producer / RAM write bus for row_dma_writer.
// master drives rows and RAM stall; slave is the DMA engine.
interface row_dma_writer_if #(
   parameter int ROW_SIZE   = 16,
   parameter int BLOCK_SIZE = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int CHANNELS   = 2
) ();
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [CHANNELS-1:0]            row_valid;
   logic [CHANNELS*ROW_SIZE-1:0]   row_data;
   logic [CHANNELS*ADDR_WIDTH-1:0] row_base_addr;
   logic [CHANNELS-1:0]            row_ready;
   logic                           ram_stall;
   logic                           ram_enable;
   logic                           ram_write;
   logic [ADDR_WIDTH-1:0]          ram_address;
   logic [BLOCK_SIZE-1:0]          output_to_ram;
   logic                           done;
   logic [CH_W-1:0]                done_channel;

   modport master (
      output row_valid, row_data, row_base_addr, ram_stall,
      input  row_ready, ram_enable, ram_write, ram_address, output_to_ram,
             done, done_channel
   );

   modport slave (
      input  row_valid, row_data, row_base_addr, ram_stall,
      output row_ready, ram_enable, ram_write, ram_address, output_to_ram,
             done, done_channel
   );
endinterface

// File: rtl/row_dma_writer.sv
// Round-robin multi-channel row DMA: latches one row per grant and writes it
// LSB-first as BLOCK_SIZE-bit words to consecutive RAM addresses.
//
// state | meaning
// IDLE  | arbitrate, latch granted row/base/channel on handshake
// WRITE | present block k each unstalled edge, hold on ram_stall
// DONE  | drop ram_enable, pulse done with done_channel
module row_dma_writer #(
   parameter int ROW_SIZE   = 16,
   parameter int BLOCK_SIZE = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int CHANNELS   = 2
) (
   input logic            clk,
   input logic            rst,
   row_dma_writer_if.slave bus
);
   localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int NUM_BLOCKS = ROW_SIZE / BLOCK_SIZE;
   localparam int KW         = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   state_t                state, state_nxt;
   logic [CH_W-1:0]       last_grant;
   logic [CH_W-1:0]       ch_q;
   logic [ROW_SIZE-1:0]   row_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [KW-1:0]         k;
   logic                  grant_vld;
   logic [CH_W-1:0]       grant_idx;
   logic [CHANNELS-1:0]   ready;
   logic                  en_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [BLOCK_SIZE-1:0] data_q;
   logic                  done_q;
   logic [CH_W-1:0]       done_ch_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= CH_W'(CHANNELS - 1);
         ch_q       <= '0;
         row_q      <= '0;
         base_q     <= '0;
         k          <= '0;
         en_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
         done_ch_q  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               en_q   <= 1'b0;
               done_q <= 1'b0;
               if (grant_vld) begin
                  row_q      <= bus.row_data[grant_idx*ROW_SIZE +: ROW_SIZE];
                  base_q     <= bus.row_base_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                  ch_q       <= grant_idx;
                  last_grant <= grant_idx;
                  k          <= '0;
               end
            end
            WRITE: begin
               done_q <= 1'b0;
               // a stalled edge leaves the presented write untouched
               if (!bus.ram_stall) begin
                  en_q   <= 1'b1;
                  addr_q <= base_q + ADDR_WIDTH'(k);
                  data_q <= row_q[k*BLOCK_SIZE +: BLOCK_SIZE];
                  k      <= k + 1'b1;
               end
            end
            DONE: begin
               en_q      <= 1'b0;
               done_q    <= 1'b1;
               done_ch_q <= ch_q;
            end
            default: begin
               en_q   <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_vld) state_nxt = WRITE;
         WRITE:   if (!bus.ram_stall && (k == KW'(NUM_BLOCKS - 1))) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // search starts one past the last winner so every channel gets a turn
   always_comb begin
      int cand;
      cand      = 0;
      grant_vld = 1'b0;
      grant_idx = '0;
      ready     = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cand = (int'(last_grant) + 1 + i) % CHANNELS;
         if (!grant_vld && bus.row_valid[cand]) begin
            grant_vld = 1'b1;
            grant_idx = CH_W'(cand);
         end
      end
      if (state == IDLE && grant_vld) ready = CHANNELS'(1) << grant_idx;
   end

   assign bus.row_ready     = ready;
   assign bus.ram_enable    = en_q;
   assign bus.ram_write     = en_q;
   assign bus.ram_address   = addr_q;
   assign bus.output_to_ram = data_q;
   assign bus.done          = done_q;
   assign bus.done_channel  = done_ch_q;
endmodule

// File: tb/tb_row_dma_writer.sv
// Directed bench for row_dma_writer with default parameters.
module tb_row_dma_writer;
   localparam int ROW_SIZE   = 16;
   localparam int BLOCK_SIZE = 4;
   localparam int ADDR_WIDTH = 16;
   localparam int CHANNELS   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   row_dma_writer_if #(
      .ROW_SIZE(ROW_SIZE), .BLOCK_SIZE(BLOCK_SIZE),
      .ADDR_WIDTH(ADDR_WIDTH), .CHANNELS(CHANNELS)
   ) bus ();

   row_dma_writer #(
      .ROW_SIZE(ROW_SIZE), .BLOCK_SIZE(BLOCK_SIZE),
      .ADDR_WIDTH(ADDR_WIDTH), .CHANNELS(CHANNELS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic do_reset;
      rst = 1'b1;
      bus.row_valid = '0;
      bus.ram_stall = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      bus.row_data = '0;
      bus.row_base_addr = '0;
      do_reset;
      #1;
      checks++;
      if ({bus.ram_enable, bus.ram_write, bus.ram_address, bus.output_to_ram,
           bus.done, bus.done_channel, bus.row_ready} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: en=%b wr=%b addr=%h data=%h done=%b ch=%b ready=%b (all required 0)",
                  bus.ram_enable, bus.ram_write, bus.ram_address, bus.output_to_ram,
                  bus.done, bus.done_channel, bus.row_ready);
      end
   endtask

   task automatic test_single_row;
      logic [3:0] exp_d [4];
      exp_d = '{4'h3, 4'hC, 4'h5, 4'hA};
      do_reset;
      bus.row_data      = {16'h0000, 16'hA5C3};
      bus.row_base_addr = {16'h0000, 16'h0100};
      bus.row_valid     = 2'b01;
      bus.ram_stall     = 1'b1;
      #1;
      checks++;
      if (bus.row_ready !== 2'b01) begin
         errors++;
         $display("FAIL single_ready: got %b required 01", bus.row_ready);
      end
      @(posedge clk);
      @(negedge clk);
      bus.row_valid = '0;
      bus.ram_stall = 1'b0;
      checks++;
      if (bus.row_ready !== 2'b00 || bus.ram_enable !== 1'b0) begin
         errors++;
         $display("FAIL single_after_grant: ready=%b en=%b required 00/0", bus.row_ready, bus.ram_enable);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bus.ram_enable !== 1'b1 || bus.ram_write !== 1'b1 ||
             bus.ram_address !== 16'h0100 + 16'(i) || bus.output_to_ram !== exp_d[i] ||
             bus.done !== 1'b0) begin
            errors++;
            $display("FAIL single_block%0d: en=%b wr=%b addr=%h data=%h done=%b required 1/1/%h/%h/0",
                     i, bus.ram_enable, bus.ram_write, bus.ram_address, bus.output_to_ram,
                     bus.done, 16'h0100 + 16'(i), exp_d[i]);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.done_channel !== 1'b0 || bus.ram_enable !== 1'b0) begin
         errors++;
         $display("FAIL single_done: done=%b ch=%b en=%b required 1/0/0",
                  bus.done, bus.done_channel, bus.ram_enable);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
         errors++;
         $display("FAIL single_done_width: done=%b required 0", bus.done);
      end
   endtask

   task automatic test_round_robin;
      int         cyc, ngr, ndone, n1, n2;
      int         gcyc [4];
      logic [1:0] gv   [4];
      logic       dch  [4];
      cyc = 0; ngr = 0; ndone = 0; n1 = 0; n2 = 0;
      gcyc = '{0, 0, 0, 0};
      do_reset;
      bus.row_data      = {16'h2222, 16'h1111};
      bus.row_base_addr = {16'h0300, 16'h0200};
      bus.row_valid     = 2'b11;
      while (ndone < 4 && cyc < 40) begin
         #1;
         if (bus.row_ready !== 2'b00 && ngr < 4) begin
            gv[ngr]   = bus.row_ready;
            gcyc[ngr] = cyc;
            ngr++;
         end
         if (bus.ram_enable === 1'b1) begin
            if (bus.output_to_ram === 4'h1) n1++;
            else if (bus.output_to_ram === 4'h2) n2++;
         end
         if (bus.done === 1'b1) begin
            dch[ndone] = bus.done_channel;
            ndone++;
         end
         @(negedge clk);
         cyc++;
      end
      bus.row_valid = '0;
      checks++;
      if (ndone != 4 || ngr != 4) begin
         errors++;
         $display("FAIL rr_timeout: dones=%0d grants=%0d required 4/4", ndone, ngr);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (gv[i] !== ((i % 2) ? 2'b10 : 2'b01) || dch[i] !== ((i % 2) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL rr_order%0d: grant=%b done_ch=%b required %b/%0d",
                     i, gv[i], dch[i], (i % 2) ? 2'b10 : 2'b01, i % 2);
         end
      end
      for (int i = 1; i < 4; i++) begin
         checks++;
         if (gcyc[i] - gcyc[i-1] != 6) begin
            errors++;
            $display("FAIL rr_period%0d: got %0d cycles required 6", i, gcyc[i] - gcyc[i-1]);
         end
      end
      checks++;
      if (n1 != 8 || n2 != 8) begin
         errors++;
         $display("FAIL rr_data: ch0 words=%0d ch1 words=%0d required 8/8", n1, n2);
      end
   endtask

   task automatic test_stall;
      logic        exp_en   [8];
      logic [15:0] exp_a    [8];
      logic [3:0]  exp_d    [8];
      logic        exp_done [8];
      exp_en   = '{1, 1, 1, 1, 1, 1, 0, 0};
      exp_a    = '{16'h0040, 16'h0041, 16'h0041, 16'h0041, 16'h0042, 16'h0043, 16'h0, 16'h0};
      exp_d    = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hB, 4'h0, 4'h0};
      exp_done = '{0, 0, 0, 0, 0, 0, 1, 0};
      do_reset;
      bus.row_data      = {16'h0000, 16'hBEEF};
      bus.row_base_addr = {16'h0000, 16'h0040};
      bus.row_valid     = 2'b01;
      @(posedge clk);
      @(negedge clk);
      bus.row_valid = '0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         checks++;
         if (bus.ram_enable !== exp_en[j] || bus.done !== exp_done[j] ||
             (exp_en[j] && (bus.ram_address !== exp_a[j] || bus.output_to_ram !== exp_d[j]))) begin
            errors++;
            $display("FAIL stall_cycle%0d: en=%b addr=%h data=%h done=%b required %b/%h/%h/%b",
                     j, bus.ram_enable, bus.ram_address, bus.output_to_ram, bus.done,
                     exp_en[j], exp_a[j], exp_d[j], exp_done[j]);
         end
         if (j == 1) bus.ram_stall = 1'b1;
         if (j == 3) bus.ram_stall = 1'b0;
      end
   endtask

   task automatic test_wrap;
      logic [15:0] exp_a [4];
      exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      do_reset;
      bus.row_data      = {16'h0000, 16'h4321};
      bus.row_base_addr = {16'h0000, 16'hFFFE};
      bus.row_valid     = 2'b01;
      @(posedge clk);
      @(negedge clk);
      bus.row_valid = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bus.ram_enable !== 1'b1 || bus.ram_address !== exp_a[i] ||
             bus.output_to_ram !== 4'(i + 1)) begin
            errors++;
            $display("FAIL wrap_block%0d: en=%b addr=%h data=%h required 1/%h/%h",
                     i, bus.ram_enable, bus.ram_address, bus.output_to_ram, exp_a[i], 4'(i + 1));
         end
      end
   endtask

   task automatic test_latch;
      logic [3:0] exp_d [4];
      exp_d = '{4'hC, 4'h3, 4'hA, 4'h5};
      do_reset;
      bus.row_data      = {16'h0000, 16'h5A3C};
      bus.row_base_addr = {16'h0000, 16'h0800};
      bus.row_valid     = 2'b01;
      @(posedge clk);
      @(negedge clk);
      bus.row_valid     = '0;
      bus.row_data      = '1;
      bus.row_base_addr = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bus.ram_enable !== 1'b1 || bus.ram_address !== 16'h0800 + 16'(i) ||
             bus.output_to_ram !== exp_d[i]) begin
            errors++;
            $display("FAIL latch_block%0d: en=%b addr=%h data=%h required 1/%h/%h",
                     i, bus.ram_enable, bus.ram_address, bus.output_to_ram,
                     16'h0800 + 16'(i), exp_d[i]);
         end
      end
   endtask

   task automatic test_reset_mid_row;
      logic [3:0] exp_d [4];
      exp_d = '{4'h6, 4'h7, 4'h8, 4'h9};
      do_reset;
      bus.row_data      = {16'h9876, 16'h1234};
      bus.row_base_addr = {16'h1230, 16'h0010};
      bus.row_valid     = 2'b01;
      @(posedge clk);
      @(negedge clk);
      bus.row_valid = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.ram_enable !== 1'b1 || bus.ram_address !== 16'h0012 || bus.output_to_ram !== 4'h2) begin
         errors++;
         $display("FAIL abort_block2: en=%b addr=%h data=%h required 1/0012/2",
                  bus.ram_enable, bus.ram_address, bus.output_to_ram);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.ram_enable, bus.ram_write, bus.ram_address, bus.output_to_ram,
           bus.done, bus.done_channel} !== '0) begin
         errors++;
         $display("FAIL abort_outputs: en=%b wr=%b addr=%h data=%h done=%b ch=%b required all 0",
                  bus.ram_enable, bus.ram_write, bus.ram_address, bus.output_to_ram,
                  bus.done, bus.done_channel);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0 || bus.ram_enable !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet%0d: done=%b en=%b required 0/0", i, bus.done, bus.ram_enable);
         end
      end
      bus.row_valid = 2'b10;
      rst = 1'b0;
      #1;
      checks++;
      if (bus.row_ready !== 2'b10) begin
         errors++;
         $display("FAIL abort_regrant: ready=%b required 10", bus.row_ready);
      end
      @(posedge clk);
      @(negedge clk);
      bus.row_valid = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bus.ram_enable !== 1'b1 || bus.ram_address !== 16'h1230 + 16'(i) ||
             bus.output_to_ram !== exp_d[i]) begin
            errors++;
            $display("FAIL abort_ch1_block%0d: en=%b addr=%h data=%h required 1/%h/%h",
                     i, bus.ram_enable, bus.ram_address, bus.output_to_ram,
                     16'h1230 + 16'(i), exp_d[i]);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.done_channel !== 1'b1) begin
         errors++;
         $display("FAIL abort_ch1_done: done=%b ch=%b required 1/1", bus.done, bus.done_channel);
      end
   endtask

   initial begin
      bus.row_valid     = '0;
      bus.row_data      = '0;
      bus.row_base_addr = '0;
      bus.ram_stall     = 1'b0;
      test_reset;
      test_single_row;
      test_round_robin;
      test_stall;
      test_wrap;
      test_latch;
      test_reset_mid_row;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/row_dma_writer.md
# row_dma_writer

Multi-channel, parametrised row-to-RAM DMA for the IO module. It accepts whole decompressed rows from up to CHANNELS producers over a valid/ready handshake, arbitrating between them round-robin. Each accepted row is serialised LSB-first into BLOCK_SIZE-bit words and written to consecutive RAM addresses starting at a per-channel base address. A RAM stall input provides backpressure, and a done pulse tagged with the channel index marks completion of each row.

## Interface
- ROW_SIZE, 16, bits per decompressed row; must be a multiple of BLOCK_SIZE
- BLOCK_SIZE, 4, bits per RAM word
- ADDR_WIDTH, 16, RAM address width
- CHANNELS, 2, number of row producers (≥1); CH_W = max(1, clog2(CHANNELS)); NUM_BLOCKS = ROW_SIZE/BLOCK_SIZE
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- row_valid  in  CHANNELS  per-channel row available
- row_data  in  CHANNELS*ROW_SIZE  channel c occupies [c*ROW_SIZE +: ROW_SIZE]
- row_base_addr  in  CHANNELS*ADDR_WIDTH  channel c start address, [c*ADDR_WIDTH +: ADDR_WIDTH]
- row_ready  out  CHANNELS  one-hot grant; combinational, asserted only in IDLE
- ram_stall  in  1  RAM cannot accept this cycle's write
- ram_enable  out  1  registered, write valid
- ram_write  out  1  registered, always equal to ram_enable
- ram_address  out  ADDR_WIDTH  registered
- output_to_ram  out  BLOCK_SIZE  registered write data
- done  out  1  registered, one-cycle pulse after the last block of a row
- done_channel  out  CH_W  registered, channel of completed row; valid while done=1

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: search channels starting at ptr = (last_grant+1) mod CHANNELS; first valid channel g gets row_ready[g]=1. At that edge, latch row_data[g], row_base_addr[g], and g; set last_grant=g; go to WRITE with block index k=0. No valid channels: stay IDLE, row_ready=0.
- WRITE, not stalled: drive ram_enable=ram_write=1, ram_address=base+k (mod 2^ADDR_WIDTH, wraps silently), output_to_ram=row[k*BLOCK_SIZE +: BLOCK_SIZE]; k++. After block NUM_BLOCKS-1 is driven, go to DONE.
- WRITE, ram_stall=1 at an edge: all outputs and k hold, so the currently presented write is re-presented. ram_stall is ignored in IDLE and DONE.
- DONE: ram_enable=ram_write=0, done=1, done_channel=g; next edge go to IDLE.
- Latched row is immune to later changes on row_data/row_base_addr.
- Reset: state IDLE, last_grant=CHANNELS-1 (so channel 0 wins first), k=0; ram_enable, ram_write, ram_address, output_to_ram, done, done_channel all 0. Reset mid-row aborts: no further writes, no done.

## Timing
- Edge E0: handshake (row_valid&row_ready) sampled.
- After E1: block 0 on RAM bus. After E(1+k): block k, absent stalls.
- Each stalled edge delays all later events by one cycle.
- After E(NUM_BLOCKS+1): ram_enable=0, done=1. After E(NUM_BLOCKS+2): state IDLE, next grant possible at that edge.
- Minimum row period: NUM_BLOCKS+2 cycles. Default parameters: 6.
- row_ready depends combinationally on row_valid and state only, never on ram_stall.

## Test plan
- Single row, ch0, data 16'hA5C3, base 16'h0100 -> writes (0100,3),(0101,C),(0102,5),(0103,A) on 4 consecutive cycles, then done=1 with done_channel=0 for exactly one cycle.
- Both channels valid continuously, ch0 data 16'h1111, ch1 data 16'h2222 -> grants alternate 0,1,0,1; each row period is 6 cycles; done_channel alternates 0,1.
- ram_stall high for 2 cycles while block 1 is presented -> block 1 and its address held for 3 cycles total; done is delayed by 2 cycles; no block is skipped or duplicated beyond the hold.
- Base 16'hFFFE, data 16'h4321 -> addresses FFFE, FFFF, 0000, 0001 with data 1, 2, 3, 4.
- rst asserted after block 2 -> next cycle all outputs 0, no done pulse; after rst release with ch1 valid only, ch1 is granted and completes normally.
- row_data changed during WRITE -> written blocks match the value latched at the handshake.
